// File: rtl/run_sequencer_if.sv
// run_sequencer_if: preload stream, result stream, core handshake and data memory port bundle
interface run_sequencer_if #(parameter int AW = 8);
  logic ld_valid, ld_ready, out_valid, out_ready, req, done, mem_sel, mem_wr_en;
  logic [7:0] ld_data, out_data, mem_wr_dat, mem_rd_dat;
  logic [AW-1:0] mem_addr;
  modport master (
    input ld_valid, ld_data, out_ready, done, mem_rd_dat,
    output ld_ready, out_valid, out_data, req, mem_sel, mem_wr_en, mem_addr, mem_wr_dat
  );
  modport slave (
    output ld_valid, ld_data, out_ready, done, mem_rd_dat,
    input ld_ready, out_valid, out_data, req, mem_sel, mem_wr_en, mem_addr, mem_wr_dat
  );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: preloads core memory, kicks and times a core run, drains results with an XOR checksum
module run_sequencer #(
  parameter int AW = 8,
  parameter int LD_BASE = 0,
  parameter int LD_LEN = 64,
  parameter int RD_BASE = 64,
  parameter int RD_LEN = 16,
  parameter int CW = 16,
  parameter int TIMEOUT = 4095
) (
  input logic clk,
  input logic reset,
  input logic start,
  output logic busy,
  output logic finished,
  output logic timeout_err,
  output logic [CW-1:0] run_cycles,
  output logic [7:0] checksum,
  run_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, DRAIN, FIN} state_t;
  typedef logic [AW:0] idx_t;
  localparam idx_t LD_LAST = idx_t'(LD_LEN - 1);
  localparam idx_t RD_LAST = idx_t'(RD_LEN - 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
  state_t state_q, state_d;
  idx_t idx_q, idx_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [7:0] chk_q, chk_d;
  logic to_q, to_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cyc_d = cyc_q;
    chk_d = chk_q;
    to_d = to_q;
    bus.ld_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data = '0;
    bus.req = 1'b0;
    bus.mem_sel = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wr_dat = '0;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = LD_LEN > 0 ? LOAD : KICK;
          idx_d = '0;
          cyc_d = '0;
          chk_d = '0;
          to_d = 1'b0;
        end
      end
      LOAD: begin
        bus.mem_sel = 1'b1;
        bus.ld_ready = 1'b1;
        bus.mem_addr = AW'(LD_BASE) + idx_q[AW-1:0];
        bus.mem_wr_dat = bus.ld_data;
        if (bus.ld_valid) begin
          bus.mem_wr_en = 1'b1;
          idx_d = idx_q + idx_t'(1);
          state_d = idx_q == LD_LAST ? KICK : LOAD;
        end
      end
      KICK: begin
        bus.req = 1'b1;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        cyc_d = cyc_q + CW'(1);
        if (bus.done) state_d = RD_LEN > 0 ? DRAIN : FIN;
        else if (cyc_d == TO_LIM) begin
          state_d = FIN;
          to_d = 1'b1;
        end
      end
      DRAIN: begin
        bus.mem_sel = 1'b1;
        bus.mem_addr = AW'(RD_BASE) + idx_q[AW-1:0];
        bus.out_valid = 1'b1;
        bus.out_data = bus.mem_rd_dat;
        if (bus.out_ready) begin
          chk_d = chk_q ^ bus.mem_rd_dat;
          idx_d = idx_q + idx_t'(1);
          state_d = idx_q == RD_LAST ? FIN : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      cyc_q <= '0;
      chk_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cyc_q <= cyc_d;
      chk_q <= chk_d;
      to_q <= to_d;
    end
  end
  assign busy = !(state_q == IDLE || state_q == FIN);
  assign finished = state_q == FIN;
  assign timeout_err = to_q;
  assign run_cycles = cyc_q;
  assign checksum = chk_q;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed and randomized sequences checked against a behavioural sequencer model
module tb_run_sequencer;
  localparam int AW = 8, LB = 0, LL = 4, RB = 64, RL = 3, CW = 16, TO = 20;
  logic clk = 1'b0;
  logic reset, start, busy, finished, timeout_err;
  logic [CW-1:0] run_cycles;
  logic [7:0] checksum;
  run_sequencer_if #(.AW(AW)) bus ();
  run_sequencer #(
    .AW(AW), .LD_BASE(LB), .LD_LEN(LL), .RD_BASE(RB), .RD_LEN(RL), .CW(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .finished(finished),
    .timeout_err(timeout_err), .run_cycles(run_cycles), .checksum(checksum), .bus(bus)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] mem [256];
  logic [7:0] lb [LL];
  int li, ldp, rdp, dly, s_cyc, req_cyc, nreq, first_ov, last_wr, stall, bad, unstable;
  bit armed, kick_force, bstart, ld_en, pend, rst_drv;
  logic [7:0] pd;
  logic [AW-1:0] pa;
  int wa[$];
  logic [7:0] wd[$], outs[$];
  assign bus.mem_rd_dat = mem[bus.mem_addr];
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    reset = rst_drv;
    start = (cyc == s_cyc) || (bstart && cyc == s_cyc + LL + 3);
    bus.ld_valid = ld_en && (ldp == 0 || (ldp == 1 && cyc[0]) || (ldp == 2 && $urandom_range(0, 1) == 1));
    bus.ld_data = li < LL ? lb[li] : 8'($urandom);
    bus.out_ready = rdp == 0 || (rdp == 1 && !(outs.size() == 1 && stall < 2)) || (rdp == 2 && $urandom_range(0, 2) != 0);
    bus.done = (kick_force && cyc == s_cyc + LL + 1) || (armed && cyc >= req_cyc + dly);
    @(negedge clk);
    if (bus.mem_wr_en) begin
      wa.push_back(int'(bus.mem_addr));
      wd.push_back(bus.mem_wr_dat);
      last_wr = cyc;
      if (!bus.mem_sel || !bus.ld_valid) bad++;
      mem[bus.mem_addr] = bus.mem_wr_dat;
    end
    if (bus.ld_valid && bus.ld_ready) li++;
    if (bus.req) begin
      nreq++;
      req_cyc = cyc;
      armed = 1'b1;
    end
    if (bus.out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      if (pend && (bus.out_data !== pd || bus.mem_addr !== pa)) unstable++;
      pend = !bus.out_ready;
      pd = bus.out_data;
      pa = bus.mem_addr;
      if (bus.out_ready) outs.push_back(bus.out_data);
      else stall++;
    end
  endtask
  task automatic arm(int d, int lp, int rp, bit kf, bit bs);
    dly = d; ldp = lp; rdp = rp; kick_force = kf; bstart = bs; ld_en = 1'b1;
    armed = 1'b0; li = 0; nreq = 0; first_ov = -1; last_wr = -1; stall = 0; bad = 0; unstable = 0; pend = 1'b0;
    wa.delete(); wd.delete(); outs.delete();
    s_cyc = cyc + 1;
  endtask
  task automatic run_seq(string tag, int d, int lp, int rp, bit kf, bit bs);
    int exp_rc, n;
    logic [7:0] x;
    bit to;
    arm(d, lp, rp, kf, bs);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(finished && n > 1) && n < 300);
    to = d > TO;
    exp_rc = to ? TO : d;
    chk({tag, ":fin/busy/to"}, {finished, busy, timeout_err}, {1'b1, 1'b0, to});
    chk({tag, ":run_cycles"}, run_cycles, exp_rc);
    chk({tag, ":req_pulses"}, nreq, 1);
    chk({tag, ":n_writes"}, wa.size(), LL);
    for (int k = 0; k < LL && k < wa.size(); k++)
      chk({tag, ":write"}, {wa[k], wd[k]}, {(LB + k) % 256, lb[k]});
    chk({tag, ":stray_writes"}, bad, 0);
    chk({tag, ":req_after_load"}, req_cyc > last_wr, 1);
    if (lp == 0) chk({tag, ":start_to_req"}, req_cyc - s_cyc, LL + 1);
    if (to) begin
      chk({tag, ":no_out_valid"}, first_ov, -1);
      chk({tag, ":checksum_zero"}, checksum, 0);
    end else begin
      x = 8'h00;
      chk({tag, ":n_out"}, outs.size(), RL);
      for (int k = 0; k < RL; k++) begin
        x ^= mem[(RB + k) % 256];
        if (k < outs.size()) chk({tag, ":out_byte"}, outs[k], mem[(RB + k) % 256]);
      end
      chk({tag, ":checksum"}, checksum, x);
      chk({tag, ":done_to_out_valid"}, first_ov - (req_cyc + d), 1);
      chk({tag, ":out_stable"}, unstable, 0);
    end
    cycle();
    cycle();
    chk({tag, ":fin_hold"}, {finished, run_cycles, nreq}, {1'b1, CW'(exp_rc), 32'd1});
  endtask
  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1; start = 1'b0; rst_drv = 1'b1; ld_en = 1'b0; s_cyc = -10; bstart = 1'b0; kick_force = 1'b0;
    armed = 1'b0; ldp = 0; rdp = 0; dly = 1000; li = 0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.out_ready = 1'b0; bus.done = 1'b0;
    cycle();
    cycle();
    rst_drv = 1'b0;
    cycle();
    chk("reset_outputs", {busy, finished, timeout_err, run_cycles, checksum, bus.ld_ready, bus.out_valid,
        bus.out_data, bus.req, bus.mem_sel, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_dat}, 0);
    lb = '{8'h11, 8'h22, 8'h33, 8'h44};
    mem[RB] = 8'h0F; mem[RB + 1] = 8'hF0; mem[RB + 2] = 8'hAA;
    run_seq("basic", 10, 0, 0, 1'b0, 1'b0);
    chk("basic:csum_55", checksum, 8'h55);
    run_seq("toggle_stall", 10, 1, 1, 1'b0, 1'b0);
    chk("toggle_stall:stalls", stall, 2);
    run_seq("timeout", 1000, 0, 0, 1'b0, 1'b0);
    run_seq("kick_done_busy_start", 5, 0, 0, 1'b1, 1'b1);
    run_seq("done_at_limit", TO, 0, 2, 1'b0, 1'b0);
    for (int k = 0; k < LL; k++) lb[k] = 8'($urandom);
    arm(10, 0, 0, 1'b0, 1'b0);
    n = 0;
    while (li < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("rst_mid:two_writes", wa.size(), 2);
    rst_drv = 1'b1; ld_en = 1'b0;
    cycle();
    rst_drv = 1'b0; ld_en = 1'b1;
    cycle();
    chk("rst_mid:outputs", {busy, finished, timeout_err, run_cycles, checksum, bus.ld_ready, bus.out_valid,
        bus.out_data, bus.req, bus.mem_sel, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_dat}, 0);
    cycle();
    cycle();
    chk("rst_mid:no_more_writes", wa.size(), 2);
    run_seq("after_reset", 7, 0, 0, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < LL; k++) lb[k] = 8'($urandom);
      for (int k = 0; k < RL; k++) mem[(RB + k) % 256] = 8'($urandom);
      run_seq("random", $urandom_range(1, 24), 2, 2, 1'b0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
